output_bram_drain: RTL and testbench
====================================

// Module: output_bram_drain
// PURPOSE
//  Read-side drain for the PE output BRAM: after all input channels are accumulated, reads the
//  NUM_PIXELS partial sums sequentially through the read port, requantises each RESULT_WIDTH
//  sum to a PIXEL_WIDTH pixel (round, shift, optional ReLU, saturate) and streams it out on a
//  valid/ready interface with a last flag. Sits between the PE output BRAM and the next layer/DMA.
// PARAMETERS
//  RESULT_WIDTH  48     width of accumulated sums read from BRAM (signed)
//  PIXEL_WIDTH   16     width of streamed output pixel (signed)
//  ADDR_WIDTH    14     BRAM address width
//  NUM_PIXELS    16384  pixels per frame (128x128); addresses 0..NUM_PIXELS-1
//  SHIFT         8      arithmetic right shift applied for requantisation (0..RESULT_WIDTH-1)
//  RELU_EN       1      1: negative results clamp to 0 before saturation
//  FIFO_DEPTH    4      output buffer depth (power of 2, >=2)
// PORTS
//  clk         in   1             clock, all logic on rising edge
//  rst_n       in   1             asynchronous active-low reset
//  start       in   1             pulse: begin draining frame (honoured only in IDLE)
//  busy        out  1             high from accepted start until done
//  done        out  1             one-cycle pulse after last pixel handshake
//  bram_en     out  1             BRAM read enable
//  bram_addr   out  ADDR_WIDTH    BRAM read address
//  bram_dout   in   RESULT_WIDTH  BRAM read data, valid the cycle after bram_en
//  m_valid     out  1             output pixel valid
//  m_ready     in   1             downstream ready
//  m_data      out  PIXEL_WIDTH   requantised pixel
//  m_last      out  1             high with final pixel (address NUM_PIXELS-1)
// BEHAVIOUR
//  Reset: busy=0, done=0, bram_en=0, bram_addr=0, m_valid=0, m_data=0, m_last=0; FIFO empty,
//   in-flight flag cleared, FSM=IDLE. Reset mid-frame discards all pending data; no done.
//  FSM: IDLE -start-> RUN (addr=0). RUN: issue reads; after read NUM_PIXELS-1 issued -> FLUSH.
//   FLUSH: wait FIFO empty and no read in flight -> DONE. DONE: done=1 one cycle -> IDLE.
//   start outside IDLE ignored.
//  Read issue (RUN only): bram_en=1 iff fifo_count + inflight < FIFO_DEPTH; address increments
//   by 1 per issued read, never wraps past NUM_PIXELS-1. inflight = bram_en registered.
//  Capture: cycle after an issued read, bram_dout is requantised and pushed into FIFO together
//   with last flag (addr==NUM_PIXELS-1). Credit rule guarantees FIFO never overflows.
//  Requant (combinational, signed): t = dout + (SHIFT>0 ? 2^(SHIFT-1) : 0) (computed RESULT_WIDTH+1
//   bits, no overflow); t >>>= SHIFT; if RELU_EN and t<0, t=0; saturate to
//   [-2^(PIXEL_WIDTH-1), 2^(PIXEL_WIDTH-1)-1].
//  Output: m_valid = FIFO non-empty; m_data/m_last = FIFO head; pop on m_valid&&m_ready.
//   m_data/m_last stable while m_valid&&!m_ready. Push and pop in same cycle allowed (count
//   unchanged). Sustained throughput 1 pixel/cycle when m_ready held high.
//  Latency: start at cycle 0 -> first bram_en cycle 1 -> first m_valid cycle 3.
//  done asserts the cycle after the m_last handshake; busy falls with done.
// TESTING
//  1 Reset/idle: rst_n low mid-run -> all outputs 0 next edge-independent; start ignored while
//    busy (second start during RUN produces exactly one frame).
//  2 Streaming, NUM_PIXELS=16, m_ready=1, BRAM[i]=i<<8, SHIFT=8 -> m_data 0..15 on consecutive
//    cycles, m_last only on 15, done one cycle later, 16 reads total.
//  3 Backpressure: random m_ready (50%) -> same ordered sequence, no drop/duplicate, m_data
//    stable while stalled, bram_en never issued with fifo_count+inflight==FIFO_DEPTH.
//  4 Rounding/ReLU: BRAM=0x180 -> 2; 0x17F -> 1; -0x100 -> 0 (RELU_EN=1) / -1 (RELU_EN=0).
//  5 Saturation: BRAM=2^30 -> 32767; BRAM=-2^30, RELU_EN=0 -> -32768.
//  6 Full frame 16384 with m_ready held low 100 cycles at start, then 1 -> 16384 pixels,
//    bram_addr ends at 16383 without wrap, single done pulse.

Source files
------------

// File: rtl/output_bram_drain_if.sv
// BRAM read port plus output pixel stream of the output BRAM drain.
// master = drain side (issues reads, sources pixels); slave = BRAM/consumer side.
// Widths follow the drain's RESULT/PIXEL/ADDR widths and must match at instantiation.
interface output_bram_drain_if #(
  parameter int RESULT_WIDTH = 48,
  parameter int PIXEL_WIDTH  = 16,
  parameter int ADDR_WIDTH   = 14
);
  logic                    bram_en;
  logic [ADDR_WIDTH-1:0]   bram_addr;
  logic [RESULT_WIDTH-1:0] bram_dout;
  logic                    m_valid;
  logic                    m_ready;
  logic [PIXEL_WIDTH-1:0]  m_data;
  logic                    m_last;

  modport master (
    output bram_en, bram_addr, m_valid, m_data, m_last,
    input  bram_dout, m_ready
  );

  modport slave (
    input  bram_en, bram_addr, m_valid, m_data, m_last,
    output bram_dout, m_ready
  );
endinterface

// File: rtl/output_bram_drain.sv
// Drains NUM_PIXELS partial sums from the PE output BRAM, requantises and streams them out.
// Latency: start -> first read 1 cycle -> first m_valid 3 cycles; 1 pixel/cycle sustained.
// Backpressure: reads issue only while buffered + in-flight pixels fit in the output FIFO.
module output_bram_drain #(
  parameter int RESULT_WIDTH = 48,
  parameter int PIXEL_WIDTH  = 16,
  parameter int ADDR_WIDTH   = 14,
  parameter int NUM_PIXELS   = 16384,
  parameter int SHIFT        = 8,
  parameter int RELU_EN      = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output_bram_drain_if.master bus
);

  localparam int PTRW = $clog2(FIFO_DEPTH);
  localparam int CW   = PTRW + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(NUM_PIXELS - 1);
  // Half an LSB of the shifted result, so the shift rounds to nearest instead of flooring.
  localparam logic signed [RESULT_WIDTH:0] RND =
    (SHIFT > 0) ? ((RESULT_WIDTH+1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;
  localparam logic signed [RESULT_WIDTH:0] PMAX =
    {{(RESULT_WIDTH-PIXEL_WIDTH+2){1'b0}}, {(PIXEL_WIDTH-1){1'b1}}};
  localparam logic signed [RESULT_WIDTH:0] PMIN =
    {{(RESULT_WIDTH-PIXEL_WIDTH+2){1'b1}}, {(PIXEL_WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    inflight_q, inflight_last_q;
  logic [CW-1:0]           count_q;
  logic [PTRW-1:0]         rd_ptr_q, wr_ptr_q;
  logic [PIXEL_WIDTH-1:0]  data_mem_q [FIFO_DEPTH];
  logic                    last_mem_q [FIFO_DEPTH];

  logic                    credit_ok, issue, push, pop, at_last;
  logic signed [RESULT_WIDTH:0] sum_w, shr_w, relu_w;
  logic [PIXEL_WIDTH-1:0]  pix_w;

  // Credit: the FIFO must have room for every read already issued plus this one.
  assign credit_ok = (count_q + CW'(inflight_q)) < CW'(FIFO_DEPTH);
  assign at_last   = (addr_q == LAST_ADDR);
  assign push      = inflight_q;
  assign pop       = bus.m_valid && bus.m_ready;

  assign bus.bram_en   = issue;
  assign bus.bram_addr = addr_q;
  assign bus.m_valid   = (count_q != '0);
  assign bus.m_data    = data_mem_q[rd_ptr_q];
  assign bus.m_last    = last_mem_q[rd_ptr_q];

  // Next-state, read issue and status outputs of the drain sequencer.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    issue   = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          addr_d  = '0;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (credit_ok) begin
          issue = 1'b1;
          if (at_last) state_d = S_FLUSH;
          else         addr_d  = addr_q + ADDR_WIDTH'(1);
        end
      end
      S_FLUSH: begin
        busy = 1'b1;
        // Leave as the final pixel is handed off so done lands the very next cycle.
        if (!inflight_q && ((count_q == '0) || (count_q == CW'(1) && pop)))
          state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Requantise the BRAM word: round, arithmetic shift, optional ReLU, saturate.
  always_comb begin
    sum_w  = $signed({bus.bram_dout[RESULT_WIDTH-1], bus.bram_dout}) + RND;
    shr_w  = sum_w >>> SHIFT;
    relu_w = ((RELU_EN != 0) && shr_w[RESULT_WIDTH]) ? '0 : shr_w;
    if (relu_w > PMAX)      pix_w = {1'b0, {(PIXEL_WIDTH-1){1'b1}}};
    else if (relu_w < PMIN) pix_w = {1'b1, {(PIXEL_WIDTH-1){1'b0}}};
    else                    pix_w = relu_w[PIXEL_WIDTH-1:0];
  end

  // Sequencer state, read address and in-flight tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      addr_q          <= addr_d;
      inflight_q      <= issue;
      inflight_last_q <= issue && at_last;
    end
  end

  // Output FIFO: capture returning reads, release on handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        data_mem_q[i] <= '0;
        last_mem_q[i] <= 1'b0;
      end
    end else begin
      if (push) begin
        data_mem_q[wr_ptr_q] <= pix_w;
        last_mem_q[wr_ptr_q] <= inflight_last_q;
        wr_ptr_q             <= wr_ptr_q + PTRW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTRW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (!push && pop) count_q <= count_q - CW'(1);
    end
  end

endmodule

// File: tb/tb_output_bram_drain.sv
// Directed bench: three drains (16 px ReLU, 16 px no ReLU, full 16384 px frame)
// with behavioural BRAMs and negedge monitors feeding a single check task.
module tb_output_bram_drain;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic busy_a, done_a, busy_b, done_b, busy_c, done_c;

  always #5 clk = ~clk;

  output_bram_drain_if #(.RESULT_WIDTH(48), .PIXEL_WIDTH(16), .ADDR_WIDTH(14)) ifa ();
  output_bram_drain_if #(.RESULT_WIDTH(48), .PIXEL_WIDTH(16), .ADDR_WIDTH(14)) ifb ();
  output_bram_drain_if #(.RESULT_WIDTH(48), .PIXEL_WIDTH(16), .ADDR_WIDTH(14)) ifc ();

  output_bram_drain #(.NUM_PIXELS(16), .RELU_EN(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .busy(busy_a), .done(done_a), .bus(ifa.master));
  output_bram_drain #(.NUM_PIXELS(16), .RELU_EN(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .busy(busy_b), .done(done_b), .bus(ifb.master));
  output_bram_drain #(.NUM_PIXELS(16384), .RELU_EN(1)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .busy(busy_c), .done(done_c), .bus(ifc.master));

  logic [47:0] mem_a [16];
  logic [47:0] mem_b [16];

  always @(posedge clk) if (ifa.bram_en) ifa.bram_dout <= mem_a[ifa.bram_addr[3:0]];
  always @(posedge clk) if (ifb.bram_en) ifb.bram_dout <= mem_b[ifb.bram_addr[3:0]];
  always @(posedge clk) if (ifc.bram_en) ifc.bram_dout <= {26'd0, ifc.bram_addr, 8'd0};

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor state
  int cyc = 0;
  logic [15:0] a_dat [$];
  logic        a_lst [$];
  int          a_hcyc [$];
  int          a_ecyc [$];
  int a_out = 0, a_done_n = 0, a_done_cyc = -1, a_credit_err = 0, a_stab_err = 0;
  logic a_stall = 1'b0, a_hold_l = 1'b0;
  logic [15:0] a_hold = '0;
  logic [15:0] b_dat [$];
  int b_done_n = 0;
  int c_hs = 0, c_en = 0, c_out = 0, c_done_n = 0;
  int c_dat_err = 0, c_lst_err = 0, c_addr_err = 0, c_credit_err = 0;
  logic [13:0] c_last_addr = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      a_out = 0; c_out = 0; a_stall = 1'b0;
    end else begin
      if (ifa.bram_en) begin
        if (a_out >= 4) a_credit_err++;
        a_out++;
        a_ecyc.push_back(cyc);
      end
      if (a_stall && (!ifa.m_valid || ifa.m_data != a_hold || ifa.m_last != a_hold_l)) a_stab_err++;
      a_stall  = ifa.m_valid && !ifa.m_ready;
      a_hold   = ifa.m_data;
      a_hold_l = ifa.m_last;
      if (ifa.m_valid && ifa.m_ready) begin
        a_dat.push_back(ifa.m_data);
        a_lst.push_back(ifa.m_last);
        a_hcyc.push_back(cyc);
        a_out--;
      end
      if (done_a) begin a_done_n++; a_done_cyc = cyc; end
      if (ifb.m_valid && ifb.m_ready) b_dat.push_back(ifb.m_data);
      if (done_b) b_done_n++;
      if (ifc.bram_en) begin
        if (c_out >= 4) c_credit_err++;
        if (ifc.bram_addr != 14'(c_en)) c_addr_err++;
        c_out++; c_en++;
        c_last_addr = ifc.bram_addr;
      end
      if (ifc.m_valid && ifc.m_ready) begin
        if (ifc.m_data != 16'(c_hs)) c_dat_err++;
        if (ifc.m_last != (c_hs == 16383)) c_lst_err++;
        c_hs++; c_out--;
      end
      if (done_c) c_done_n++;
    end
    cyc++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic int done_cnt(input int sel);
    return (sel == 0) ? a_done_n : (sel == 1) ? b_done_n : c_done_n;
  endfunction

  task automatic wait_done(input int sel, input int base, input int budget, input string tag);
    int n = 0;
    while (done_cnt(sel) == base && n < budget) begin
      tick(1);
      n++;
    end
    check(tag, 64'(done_cnt(sel) != base), 1);
  endtask

  logic [15:0] exp_a [8] = '{16'h0002, 16'h0001, 16'h0000, 16'h7FFF, 16'h0000, 16'h0000, 16'h7FFF, 16'h7FFF};
  logic [15:0] exp_b [8] = '{16'h0002, 16'h0001, 16'hFFFF, 16'h7FFF, 16'h8000, 16'hFFFF, 16'h7FFF, 16'h7FFF};

  initial begin
    int hb, eb, db, dbb, s0, cdb;
    ifa.m_ready = 1'b1; ifb.m_ready = 1'b1; ifc.m_ready = 1'b1;
    #1 rst_n = 1'b0;
    tick(2);

    // Reset values
    check("rst_busy", 64'(busy_a), 0);
    check("rst_done", 64'(done_a), 0);
    check("rst_bram", 64'({ifa.bram_en, ifa.bram_addr}), 0);
    check("rst_stream", 64'({ifa.m_valid, ifa.m_data, ifa.m_last}), 0);
    rst_n = 1'b1;
    tick(2);

    // Streaming at full rate, with a second start during RUN
    for (int i = 0; i < 16; i++) mem_a[i] = 48'(i) << 8;
    hb = a_dat.size(); eb = a_ecyc.size(); db = a_done_n;
    s0 = cyc;
    start_a = 1'b1; tick(1); start_a = 1'b0;
    tick(1);
    check("t2_busy", 64'(busy_a), 1);
    tick(3);
    start_a = 1'b1; tick(1); start_a = 1'b0;
    wait_done(0, db, 100, "t2_done_seen");
    tick(10);
    check("t2_count", 64'(a_dat.size() - hb), 16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t2_data%0d", i), 64'(a_dat[hb+i]), 64'(i));
      check($sformatf("t2_last%0d", i), 64'(a_lst[hb+i]), 64'(i == 15));
    end
    check("t2_first_en", 64'(a_ecyc[eb]), 64'(s0 + 1));
    check("t2_first_valid", 64'(a_hcyc[hb]), 64'(s0 + 3));
    check("t2_back_to_back", 64'(a_hcyc[hb+15] - a_hcyc[hb]), 15);
    check("t2_reads", 64'(a_ecyc.size() - eb), 16);
    check("t2_done_lat", 64'(a_done_cyc), 64'(a_hcyc[hb+15] + 1));
    check("t2_one_done", 64'(a_done_n - db), 1);
    check("t2_idle", 64'(busy_a), 0);

    // Random backpressure
    hb = a_dat.size(); db = a_done_n;
    start_a = 1'b1; tick(1); start_a = 1'b0;
    for (int n = 0; n < 400 && a_done_n == db; n++) begin
      ifa.m_ready = 1'($urandom_range(0, 1));
      tick(1);
    end
    ifa.m_ready = 1'b1;
    check("t3_done_seen", 64'(a_done_n - db), 1);
    check("t3_count", 64'(a_dat.size() - hb), 16);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("t3_data%0d", i), 64'(a_dat[hb+i]), 64'(i));
      check($sformatf("t3_last%0d", i), 64'(a_lst[hb+i]), 64'(i == 15));
    end
    check("t3_stable", 64'(a_stab_err), 0);
    check("t3_credit", 64'(a_credit_err), 0);

    // Reset in the middle of a frame
    hb = a_dat.size(); db = a_done_n;
    ifa.m_ready = 1'b0;
    start_a = 1'b1; tick(1); start_a = 1'b0;
    tick(12);
    check("t1_fill_valid", 64'(ifa.m_valid), 1);
    check("t1_fill_busy", 64'(busy_a), 1);
    #2 rst_n = 1'b0;
    #1;
    check("t1_rst_busy", 64'({busy_a, done_a}), 0);
    check("t1_rst_bram", 64'({ifa.bram_en, ifa.bram_addr}), 0);
    check("t1_rst_stream", 64'({ifa.m_valid, ifa.m_data, ifa.m_last}), 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    ifa.m_ready = 1'b1;
    tick(20);
    check("t1_no_done", 64'(a_done_n - db), 0);
    check("t1_no_pixels", 64'(a_dat.size() - hb), 0);
    check("t1_idle", 64'({busy_a, ifa.m_valid}), 0);

    // Rounding, ReLU and saturation
    for (int i = 0; i < 16; i++) begin mem_a[i] = '0; mem_b[i] = '0; end
    mem_a[0] = 48'h180;        mem_a[1] = 48'h17F;
    mem_a[2] = -48'sd256;      mem_a[3] = 48'd1 << 30;
    mem_a[4] = -(48'sd1 << 30); mem_a[5] = -48'sd129;
    mem_a[6] = 48'h7FFF80;     mem_a[7] = 48'h7FFF00;
    for (int i = 0; i < 8; i++) mem_b[i] = mem_a[i];
    hb = a_dat.size(); dbb = b_dat.size(); db = a_done_n; eb = b_done_n;
    start_a = 1'b1; start_b = 1'b1; tick(1); start_a = 1'b0; start_b = 1'b0;
    wait_done(0, db, 100, "t4_done_a");
    wait_done(1, eb, 100, "t4_done_b");
    for (int i = 0; i < 8; i++) begin
      check($sformatf("t4_relu%0d", i), 64'(a_dat[hb+i]), 64'(exp_a[i]));
      check($sformatf("t4_norelu%0d", i), 64'(b_dat[dbb+i]), 64'(exp_b[i]));
    end

    // Full 16384-pixel frame, consumer stalled for the first 100 cycles
    cdb = c_done_n;
    ifc.m_ready = 1'b0;
    start_c = 1'b1; tick(1); start_c = 1'b0;
    tick(100);
    check("t6_stall_reads", 64'(c_en), 4);
    ifc.m_ready = 1'b1;
    wait_done(2, cdb, 17000, "t6_done_seen");
    tick(5);
    check("t6_pixels", 64'(c_hs), 16384);
    check("t6_reads", 64'(c_en), 16384);
    check("t6_data", 64'(c_dat_err), 0);
    check("t6_last", 64'(c_lst_err), 0);
    check("t6_addr_seq", 64'(c_addr_err), 0);
    check("t6_credit", 64'(c_credit_err), 0);
    check("t6_last_addr", 64'(c_last_addr), 16383);
    check("t6_addr_hold", 64'(ifc.bram_addr), 16383);
    check("t6_one_done", 64'(c_done_n - cdb), 1);
    check("t6_idle", 64'(busy_c), 0);
    check("final_credit_a", 64'(a_credit_err), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
